blinken_chase: RTL

//   Parametrised LED driver; next generation of the board's power-on blinker.

---
 rtl/blinken_pkg.sv | 20 ++
 rtl/blinken_tick_div.sv | 31 +++
 rtl/blinken_chase.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/blinken_pkg.sv
// Shared definitions for the blinken LED driver: output modes, FSM states
// and a counter-width helper.
package blinken_pkg;

    localparam logic [1:0] MODE_STEADY    = 2'd0;
    localparam logic [1:0] MODE_BLINK     = 2'd1;
    localparam logic [1:0] MODE_DIM       = 2'd2;
    localparam logic [1:0] MODE_BLINK_DIM = 2'd3;

    typedef enum logic {
        ST_SPLASH = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Bits needed to hold 0..limit-1, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/blinken_tick_div.sv
// Timebase divider: a one-clock tick pulse every CLOCK_HZ/TICK_HZ clocks,
// asserted while the prescaler sits on its terminal count.
module blinken_tick_div #(
    parameter int CLOCK_HZ = 1_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    import blinken_pkg::*;

    localparam int            DIV  = CLOCK_HZ / TICK_HZ;
    localparam int            W    = cnt_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/blinken_chase.sv
// LED driver: bouncing one-hot chase splash after reset or on request, then
// the host value gated by steady, blink, PWM-dim or blink+dim mode.
module blinken_chase #(
    parameter int NUM_LEDS      = 8,
    parameter int CLOCK_HZ      = 1_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int STEP_TICKS    = 50,
    parameter int SPLASH_PASSES = 4,
    parameter int BLINK_TICKS   = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] value,
    input  logic [1:0]          mode,
    input  logic [7:0]          brightness,
    input  logic                splash_req,
    output logic                splashing,
    output logic [NUM_LEDS-1:0] leds
);
    import blinken_pkg::*;

    localparam int POS_W   = cnt_width(NUM_LEDS);
    localparam int SEG_W   = cnt_width(NUM_LEDS - 1);
    localparam int STEP_W  = cnt_width(STEP_TICKS);
    localparam int PASS_W  = cnt_width(SPLASH_PASSES);
    localparam int BLINK_W = cnt_width(BLINK_TICKS);

    localparam logic [POS_W-1:0]   POS_PEN    = POS_W'(NUM_LEDS - 2);
    localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(NUM_LEDS - 2);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_TICKS - 1);
    localparam logic [PASS_W-1:0]  PASS_LAST  = PASS_W'(SPLASH_PASSES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic tick;

    blinken_tick_div #(
        .CLOCK_HZ (CLOCK_HZ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    state_t state;
    state_t state_next;

    logic [POS_W-1:0]   pos;
    logic               dir_down;
    logic [STEP_W-1:0]  step_cnt;
    logic [SEG_W-1:0]   seg_cnt;
    logic [PASS_W-1:0]  pass_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic [7:0]         pwm_cnt;
    logic               pwm_on;
    logic               gate;
    logic               step_done;
    logic               splash_done;
    logic               restart;

    assign step_done   = (state == ST_SPLASH) && tick && (step_cnt == STEP_LAST);
    assign splash_done = step_done && (seg_cnt == SEG_LAST) && (pass_cnt == PASS_LAST);
    assign restart     = (state == ST_RUN) && splash_req;
    assign pwm_on      = (pwm_cnt < brightness);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_SPLASH: if (splash_done) state_next = ST_RUN;
            ST_RUN:    if (splash_req)  state_next = ST_SPLASH;
            default:   state_next = ST_SPLASH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_SPLASH;
            splashing <= 1'b1;
        end else begin
            state     <= state_next;
            splashing <= (state_next == ST_SPLASH);
        end
    end

    // Chase position bounces between the end LEDs, one step per STEP_TICKS ticks.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            pos      <= '0;
            dir_down <= 1'b0;
            step_cnt <= '0;
            seg_cnt  <= '0;
            pass_cnt <= '0;
        end else if (step_done) begin
            step_cnt <= '0;
            if (dir_down) begin
                pos <= pos - POS_W'(1);
                if (pos == POS_W'(1)) dir_down <= 1'b0;
            end else begin
                pos <= pos + POS_W'(1);
                if (pos == POS_PEN) dir_down <= 1'b1;
            end
            if (seg_cnt == SEG_LAST) begin
                seg_cnt  <= '0;
                pass_cnt <= (pass_cnt == PASS_LAST) ? '0 : pass_cnt + PASS_W'(1);
            end else begin
                seg_cnt <= seg_cnt + SEG_W'(1);
            end
        end else if (state == ST_SPLASH && tick) begin
            step_cnt <= step_cnt + STEP_W'(1);
        end
    end

    // Blink phase is held at "on" through the splash, so RUN always starts lit.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (state == ST_SPLASH) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    always_comb begin
        gate = 1'b1;
        case (mode)
            MODE_STEADY:    gate = 1'b1;
            MODE_BLINK:     gate = blink_on;
            MODE_DIM:       gate = pwm_on;
            MODE_BLINK_DIM: gate = blink_on & pwm_on;
            default:        gate = 1'b1;
        endcase
    end

    // A splash request shows the first chase LED on the same edge the FSM re-enters SPLASH.
    always_ff @(posedge clock) begin
        if (reset) begin
            leds <= '0;
        end else if (state == ST_SPLASH) begin
            leds <= NUM_LEDS'(1) << pos;
        end else if (splash_req) begin
            leds <= NUM_LEDS'(1);
        end else begin
            leds <= value & {NUM_LEDS{gate}};
        end
    end

endmodule
